// File: rtl/dog_pkg.sv
// Shared state encoding, fixed-point widths and reset constants for the dog physics engine.
package dog_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UPDATE  = 2'd1,
    COLLIDE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int POS_FRAC = 8;
  localparam int VEL_W    = 12;

  localparam int RST_X0 = 64;
  localparam int RST_DX = 128;
  localparam int RST_Y  = 100;
  localparam int RST_VX = 256;
  localparam int RST_VY = 128;
endpackage

// File: rtl/dog_axis_update.sv
// One axis of one dog, purely combinational: thrust, friction, speed clamp, integrate, wall bounce.
module dog_axis_update
  import dog_pkg::*;
#(
  parameter int P_W        = 18,
  parameter int LIMIT_PX   = 592,
  parameter int ACCEL      = 32,
  parameter int FRIC_SHIFT = 6,
  parameter int VMAX       = 1024
) (
  input  logic [P_W-1:0]   i_p,
  input  logic [VEL_W-1:0] i_v,
  input  logic             i_pos,
  input  logic             i_neg,
  output logic [P_W-1:0]   o_p,
  output logic [VEL_W-1:0] o_v
);
  localparam int VW = VEL_W + 2;
  localparam logic signed [VW-1:0] W_ACC  = VW'(ACCEL);
  localparam logic signed [VW-1:0] W_ZERO = '0;
  localparam logic signed [VW-1:0] W_VMAX = VW'(VMAX);
  localparam logic signed [P_W:0]  W_LIM  = (P_W+1)'(LIMIT_PX << POS_FRAC);

  logic signed [VW-1:0] w_v0, w_v1, w_v2, w_v3, w_vb;
  logic signed [P_W:0]  w_vext, w_pn;

  always_comb begin
    w_v0 = {{2{i_v[VEL_W-1]}}, i_v};
    w_v1 = w_v0 + (i_pos ? W_ACC : W_ZERO) - (i_neg ? W_ACC : W_ZERO);
    w_v2 = w_v1 - (w_v1 >>> FRIC_SHIFT);
    if (w_v2 > W_VMAX)       w_v3 = W_VMAX;
    else if (w_v2 < -W_VMAX) w_v3 = -W_VMAX;
    else                     w_v3 = w_v2;
    w_vb   = -(w_v3 >>> 1);
    // One guard bit above the position width makes a negative p' visible.
    w_vext = {{(P_W+1-VW){w_v3[VW-1]}}, w_v3};
    w_pn   = $signed({1'b0, i_p}) + w_vext;
    o_p = P_W'(w_pn);
    o_v = VEL_W'(w_v3);
    if (w_pn < 0) begin
      o_p = '0;
      o_v = VEL_W'(w_vb);
    end else if (w_pn > W_LIM) begin
      o_p = P_W'(W_LIM);
      o_v = VEL_W'(w_vb);
    end
  end
endmodule

// File: rtl/dog_physics_engine.sv
// Per-frame sequencer: updates one dog per cycle, then optionally tests one pair per cycle for overlap.
// Define DOG_COLLIDE_EN to compile in the COLLIDE state, overlap flags and hit counters.
module dog_physics_engine
  import dog_pkg::*;
#(
  parameter int N_DOGS     = 4,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BOX_W      = 48,
  parameter int BOX_H      = 32,
  parameter int ACCEL      = 32,
  parameter int FRIC_SHIFT = 6,
  parameter int VMAX       = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic [N_DOGS*4-1:0]    ctrl,
  output logic [N_DOGS*10-1:0]   pos_x,
  output logic [N_DOGS*9-1:0]    pos_y,
  output logic [N_DOGS*12-1:0]   vel_x,
  output logic [N_DOGS*12-1:0]   vel_y,
  output logic [N_DOGS*8-1:0]    hits,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);
  localparam int XW = 10 + POS_FRAC;
  localparam int YW = 9 + POS_FRAC;
  localparam logic [1:0] LAST = 2'(N_DOGS - 1);
`ifdef DOG_COLLIDE_EN
  localparam bit COLL_EN = (N_DOGS > 1);
`else
  localparam bit COLL_EN = 1'b0;
`endif

  state_t r_state, w_next;
  logic [1:0]       r_idx;
  logic             r_overrun;
  logic [XW-1:0]    r_px [N_DOGS];
  logic [YW-1:0]    r_py [N_DOGS];
  logic [VEL_W-1:0] r_vx [N_DOGS];
  logic [VEL_W-1:0] r_vy [N_DOGS];
  logic [3:0]       w_ctl [N_DOGS];
  logic [3:0]       w_cur;
  logic [XW-1:0]    w_px_n;
  logic [YW-1:0]    w_py_n;
  logic [VEL_W-1:0] w_vx_n, w_vy_n;
  logic             w_last_pair;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (frame_tick) w_next = UPDATE;
      UPDATE:  if (r_idx == LAST) w_next = COLL_EN ? COLLIDE : DONE;
      COLLIDE: if (w_last_pair) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_idx     <= (r_state == UPDATE) ? r_idx + 2'd1 : 2'd0;
      r_overrun <= frame_tick && (r_state != IDLE);
    end
  end

  assign w_cur = w_ctl[r_idx];

  // ctrl nibble is {up,down,left,right}; screen y grows downward.
  dog_axis_update #(.P_W(XW), .LIMIT_PX(SCREEN_W - BOX_W), .ACCEL(ACCEL),
                    .FRIC_SHIFT(FRIC_SHIFT), .VMAX(VMAX)) u_axis_x (
    .i_p(r_px[r_idx]), .i_v(r_vx[r_idx]), .i_pos(w_cur[0]), .i_neg(w_cur[1]),
    .o_p(w_px_n), .o_v(w_vx_n)
  );

  dog_axis_update #(.P_W(YW), .LIMIT_PX(SCREEN_H - BOX_H), .ACCEL(ACCEL),
                    .FRIC_SHIFT(FRIC_SHIFT), .VMAX(VMAX)) u_axis_y (
    .i_p(r_py[r_idx]), .i_v(r_vy[r_idx]), .i_pos(w_cur[2]), .i_neg(w_cur[3]),
    .o_p(w_py_n), .o_v(w_vy_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_DOGS; k++) begin
        r_px[k] <= XW'((RST_X0 + RST_DX * k) << POS_FRAC);
        r_py[k] <= YW'(RST_Y << POS_FRAC);
        r_vx[k] <= VEL_W'(RST_VX);
        r_vy[k] <= VEL_W'(RST_VY);
      end
    end else if (r_state == UPDATE) begin
      r_px[r_idx] <= w_px_n;
      r_py[r_idx] <= w_py_n;
      r_vx[r_idx] <= w_vx_n;
      r_vy[r_idx] <= w_vy_n;
    end
  end

`ifdef DOG_COLLIDE_EN
  localparam int NP = (N_DOGS > 1) ? N_DOGS * (N_DOGS - 1) / 2 : 1;

  logic [1:0]    r_ci, r_cj;
  logic [2:0]    r_pair;
  logic [NP-1:0] r_ovl;
  logic [7:0]    r_hits [N_DOGS];
  logic [9:0]    w_xi, w_xj, w_dx;
  logic [8:0]    w_yi, w_yj, w_dy;
  logic          w_ov;

  always_comb begin
    w_xi = r_px[r_ci][XW-1:POS_FRAC];
    w_xj = r_px[r_cj][XW-1:POS_FRAC];
    w_yi = r_py[r_ci][YW-1:POS_FRAC];
    w_yj = r_py[r_cj][YW-1:POS_FRAC];
    w_dx = (w_xi > w_xj) ? w_xi - w_xj : w_xj - w_xi;
    w_dy = (w_yi > w_yj) ? w_yi - w_yj : w_yj - w_yi;
    w_ov = (w_dx < 10'(BOX_W)) && (w_dy < 9'(BOX_H));
    w_last_pair = (r_pair == 3'(NP - 1));
  end

  // Hits count entries into overlap, not frames spent overlapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ci   <= 2'd0;
      r_cj   <= 2'd1;
      r_pair <= '0;
      r_ovl  <= '0;
      for (int k = 0; k < N_DOGS; k++) r_hits[k] <= '0;
    end else if (r_state == COLLIDE) begin
      r_ovl[r_pair] <= w_ov;
      if (w_ov && !r_ovl[r_pair]) begin
        if (r_hits[r_ci] != 8'hFF) r_hits[r_ci] <= r_hits[r_ci] + 8'd1;
        if (r_hits[r_cj] != 8'hFF) r_hits[r_cj] <= r_hits[r_cj] + 8'd1;
      end
      if (w_last_pair) begin
        r_ci   <= 2'd0;
        r_cj   <= 2'd1;
        r_pair <= '0;
      end else begin
        r_pair <= r_pair + 3'd1;
        if (r_cj == LAST) begin
          r_ci <= r_ci + 2'd1;
          r_cj <= r_ci + 2'd2;
        end else begin
          r_cj <= r_cj + 2'd1;
        end
      end
    end
  end
`else
  assign w_last_pair = 1'b1;
  assign hits        = '0;
`endif

  for (genvar k = 0; k < N_DOGS; k++) begin : g_dog
    assign w_ctl[k]            = ctrl[4*k +: 4];
    assign pos_x[10*k +: 10]   = r_px[k][XW-1:POS_FRAC];
    assign pos_y[9*k +: 9]     = r_py[k][YW-1:POS_FRAC];
    assign vel_x[12*k +: 12]   = r_vx[k];
    assign vel_y[12*k +: 12]   = r_vy[k];
`ifdef DOG_COLLIDE_EN
    assign hits[8*k +: 8]      = r_hits[k];
`endif
  end

  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == DONE);
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_dog_physics_engine.sv
// Directed bench for dog_physics_engine (4 dogs); collision checks compile in with DOG_COLLIDE_EN.
`timescale 1ns/1ps
module tb_dog_physics_engine;
  localparam int N = 4;
`ifdef DOG_COLLIDE_EN
  localparam int DONE_IDX = N + N * (N - 1) / 2;
`else
  localparam int DONE_IDX = N;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           frame_tick = 1'b0;
  logic [4*N-1:0] ctrl = '0;
  logic [10*N-1:0] pos_x;
  logic [9*N-1:0]  pos_y;
  logic [12*N-1:0] vel_x, vel_y;
  logic [8*N-1:0]  hits;
  logic            busy, frame_done, overrun;

  int n_chk  = 0;
  int n_fail = 0;

  dog_physics_engine #(.N_DOGS(N)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .ctrl(ctrl),
    .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x), .vel_y(vel_y),
    .hits(hits), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int px(input int k); return int'(pos_x[10*k +: 10]); endfunction
  function automatic int py(input int k); return int'(pos_y[9*k +: 9]); endfunction
  function automatic int vx(input int k); return int'($signed(vel_x[12*k +: 12])); endfunction
  function automatic int vy(input int k); return int'($signed(vel_y[12*k +: 12])); endfunction
  function automatic int hit(input int k); return int'(hits[8*k +: 8]); endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    frame_tick = 1'b0;
    ctrl = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset(input string pfx);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_px%0d", pfx, k), px(k), 64 + 128 * k);
      check($sformatf("%s_py%0d", pfx, k), py(k), 100);
      check($sformatf("%s_vx%0d", pfx, k), vx(k), 256);
      check($sformatf("%s_vy%0d", pfx, k), vy(k), 128);
      check($sformatf("%s_hit%0d", pfx, k), hit(k), 0);
    end
    check({pfx, "_busy"}, int'(busy), 0);
    check({pfx, "_done"}, int'(frame_done), 0);
    check({pfx, "_ovr"}, int'(overrun), 0);
  endtask

  // Tick, wait (bounded) for frame_done, then one more cycle so the FSM is back in IDLE.
  task automatic run_frame(input logic [4*N-1:0] c);
    int d;
    ctrl = c;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    d = -1;
    for (int i = 0; i < 100; i++) begin
      if (frame_done) begin
        d = i;
        break;
      end
      @(negedge clk);
    end
    if (d < 0) check("frame_done_timeout", d, DONE_IDX);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, maxv, maxp, prev, av;
    bit clamp_seen;

    do_reset();
    check_reset("por");

    // First frame: per-dog write timing, overrun on a tick while busy, done timing.
    ctrl = '0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check("busy_t0", int'(busy), 1);
    @(negedge clk);
    check("vx0_after_t1", vx(0), 252);
    check("vx1_after_t1", vx(1), 256);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check("overrun_pulse", int'(overrun), 1);
    @(negedge clk);
    check("overrun_clear", int'(overrun), 0);
    d = -1;
    for (int i = 4; i < 60; i++) begin
      if (frame_done) begin
        d = i;
        break;
      end
      @(negedge clk);
    end
    check("done_cycle", d, DONE_IDX);
    @(negedge clk);
    check("done_one_cycle", int'(frame_done), 0);
    check("idle_after_done", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("no_restart", int'(busy), 0);
    check("f1_vx0", vx(0), 252);
    check("f1_vy0", vy(0), 126);
    check("f1_px0", px(0), 64);
    check("f1_py0", py(0), 100);
    check("f1_vx3", vx(3), 252);
    check("f1_px3", px(3), 448);

    run_frame('0);
    check("f2_vx0", vx(0), 249);
    check("f2_px0", px(0), 65);
    check("f2_vy0", vy(0), 125);
    check("f2_py0", py(0), 100);

    // Thrust in each direction on a different dog.
    do_reset();
    run_frame(16'h4821);
    check("thr_right_vx0", vx(0), 284);
    check("thr_none_vy0", vy(0), 126);
    check("thr_left_vx1", vx(1), 221);
    check("thr_up_vy2", vy(2), 95);
    check("thr_down_vy3", vy(3), 158);
    do_reset();
    run_frame(16'h000F);
    check("thr_lr_cancel_vx0", vx(0), 252);
    check("thr_ud_cancel_vy0", vy(0), 126);

    // Reset pulsed mid-frame, just after dog 0 was written.
    do_reset();
    ctrl = '0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
    check("mid_vx0_written", vx(0), 252);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("in_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("post_rst");
    run_frame('0);
    check("rerun_vx0", vx(0), 252);
    check("rerun_vx1", vx(1), 252);
    check("rerun_px0", px(0), 64);
    check("rerun_vy0", vy(0), 126);

    // Right held: speed saturates, then the right wall clamps and bounces.
    do_reset();
    maxv = 0; maxp = 0; prev = 256; clamp_seen = 1'b0;
    for (int f = 0; f < 200; f++) begin
      run_frame(16'h0001);
      av = (vx(0) < 0) ? -vx(0) : vx(0);
      if (av > maxv) maxv = av;
      if (px(0) > maxp) maxp = px(0);
      if (!clamp_seen && vx(0) < 0) begin
        clamp_seen = 1'b1;
        check("clamp_px", px(0), 592);
        check("clamp_prev_vx", prev, 1024);
        check("clamp_vx", vx(0), -512);
      end
      prev = vx(0);
    end
    check("vmax_bound", int'(maxv <= 1024), 1);
    check("pmax_bound", int'(maxp <= 592), 1);
    check("pmax_reached", maxp, 592);
    check("clamp_seen", int'(clamp_seen), 1);

`ifdef DOG_COLLIDE_EN
    // Dog 0 right, dog 1 left: hits follow rising edges of each pair's overlap.
    begin
      int  exp_h [N];
      bit  pov [N][N];
      bit  ov;
      int  dx, dy;
      do_reset();
      for (int k = 0; k < N; k++) exp_h[k] = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) pov[i][j] = 1'b0;
      for (int f = 0; f < 120; f++) begin
        run_frame(16'h0021);
        for (int i = 0; i < N; i++) begin
          for (int j = i + 1; j < N; j++) begin
            dx = px(i) - px(j);
            dy = py(i) - py(j);
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            ov = (dx < 48) && (dy < 32);
            if (ov && !pov[i][j]) begin
              if (exp_h[i] < 255) exp_h[i]++;
              if (exp_h[j] < 255) exp_h[j]++;
            end
            pov[i][j] = ov;
          end
        end
        for (int k = 0; k < N; k++)
          check($sformatf("coll_f%0d_hit%0d", f, k), hit(k), exp_h[k]);
      end
      check("coll_dog0_hit_seen", int'(exp_h[0] >= 1), 1);
    end
`else
    for (int k = 0; k < N; k++) check($sformatf("nocoll_hit%0d", k), hit(k), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
